div10_seq_ctrl: RTL and testbench
=================================

Name: div10_seq_ctrl

Overview:
- Sequential controller that computes the tens digit (quotient) and units digit (remainder) of an unsigned operand by repeated subtraction of the divisor.
- Flags when the tens digit equals a target value (default: tens == 6, i.e. operand 60..63 at WIDTH=6).
- Sits between a stimulus/operand source and display or decision logic.
- Uses a start/busy/done handshake; results are held stable until the next completion.

Parameters:
- WIDTH, 6, operand/quotient/remainder width in bits.
- DIVISOR, 10, constant subtracted per step; must be >= 1 and < 2^WIDTH.
- MATCH, 6, quotient value that sets is_match.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- i  input  WIDTH  operand; captured on the accepting edge only.
- busy  output  1  high in SUB and DONE states.
- done  output  1  one-cycle pulse; results valid.
- quot  output  WIDTH  registered quotient (i / DIVISOR).
- rem  output  WIDTH  registered remainder (i % DIVISOR).
- is_match  output  1  registered (quot == MATCH).

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, quot=0, rem=0, is_match=0; internal accumulators cleared.
- Reset is effective immediately, including mid-operation. After release the block sits in IDLE and waits for a new start.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - If start=1 at a clock edge: acc_r <= i, acc_q <= 0, go to SUB, busy=1.
  - Otherwise stay in IDLE.
- SUB, one compare per edge:
  - If acc_r >= DIVISOR: acc_r <= acc_r - DIVISOR, acc_q <= acc_q + 1, stay in SUB.
  - Else: quot <= acc_q, rem <= acc_r, is_match <= (acc_q == MATCH), done <= 1, go to DONE.
- DONE:
  - done is high for exactly this one cycle.
  - Next edge: done <= 0, busy <= 0, go to IDLE.
- Latency: with q = i / DIVISOR, done is high in the cycle following edge E0+q+1, where E0 is the accepting edge.
  - Total busy window: q+2 cycles.
  - WIDTH=6 worst case is i=63: done 7 edges after accept, 8 busy cycles.
- Handshake:
  - start is ignored while busy=1, including in DONE.
  - A start held high continuously is re-accepted on the first IDLE edge after DONE, which gives back-to-back ops with one IDLE cycle between.
  - The value of i is don't-care except on the accepting edge.
- Output hold: quot, rem and is_match change only on the SUB->DONE transition and hold through IDLE and the next operation until that operation completes.
- Arithmetic: unsigned throughout. acc_r never underflows because the subtraction is guarded by the compare. acc_q cannot exceed (2^WIDTH-1)/DIVISOR, so no wrap-around.
- i=0 or i<DIVISOR: first SUB edge completes; quot=0, rem=i.

Optional Feature:
- Macro: DIV10_SEQ_CTRL_MATCH_CNT_EN.
- Defined:
  - Adds output match_cnt [7:0].
  - Reset value 0 (async).
  - Increments on the SUB->DONE edge when the new is_match=1.
  - Saturates at 255; no wrap.
- Undefined: port and counter are absent; all other behaviour identical.

Test Plan:
- Reset, then start with i=63 → busy=1 next cycle; done pulses exactly 7 edges after accept; quot=6, rem=3, is_match=1; busy low the cycle after done.
- i=59 → done after 6 edges; quot=5, rem=9, is_match=0. Then i=60 → quot=6, rem=0, is_match=1.
- i=0 → done 1 edge after accept; quot=0, rem=0, is_match=0. i=9 → quot=0, rem=9.
- Start accepted with i=40; pulse start with i=63 two cycles later (while busy) → ignored; result quot=4, rem=0. No second done until start is reasserted in IDLE.
- Start i=63; assert rst_n=0 three cycles later → busy, done, quot, rem, is_match all 0 immediately; after release there is no done until a new start.
- With DIV10_SEQ_CTRL_MATCH_CNT_EN: sweep i=0..63 sequentially → match_cnt=4 at end. Then 260 ops with i=61 → match_cnt=255 (saturated).

Source files
------------

// File: rtl/div10_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div10_seq_ctrl
//
// Sequential divide-by-constant controller. It finds the quotient (tens digit)
// and remainder (units digit) of an unsigned operand by repeatedly
// subtracting DIVISOR, one compare per clock. It flags results whose quotient
// equals MATCH.
//
// Handshake: a start seen in IDLE captures the operand. busy stays high while
// the subtraction runs and during the one-cycle done pulse. quot/rem/is_match
// hold their values until the next operation completes.
//
// Parameters:
//   WIDTH    operand / quotient / remainder width in bits
//   DIVISOR  constant subtracted per step (1 .. 2^WIDTH-1)
//   MATCH    quotient value that raises is_match
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request; sampled only in IDLE
//   i          in   operand [WIDTH], captured on the accepting edge only
//   busy       out  high in SUB and DONE
//   done       out  one-cycle pulse, results valid
//   quot       out  registered quotient  [WIDTH]
//   rem        out  registered remainder [WIDTH]
//   is_match   out  registered (quot == MATCH)
//   match_cnt  out  [8] saturating count of matching results; present only
//                   when DIV10_SEQ_CTRL_MATCH_CNT_EN is defined
//
// Optional build macro: DIV10_SEQ_CTRL_MATCH_CNT_EN
// ---------------------------------------------------------------------------
module div10_seq_ctrl #(
    parameter int WIDTH   = 6,
    parameter int DIVISOR = 10,
    parameter int MATCH   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             is_match
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
    ,
    output logic [7:0]       match_cnt
`endif
);

    localparam logic [WIDTH-1:0] DIV_W   = WIDTH'(DIVISOR);
    localparam logic [WIDTH-1:0] MATCH_W = WIDTH'(MATCH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_rem_q, acc_rem_d;   // running remainder
    logic [WIDTH-1:0] acc_quo_q, acc_quo_d;   // running quotient
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             match_q, match_d;
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
    logic [7:0]       cnt_q, cnt_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_rem_q <= '0;
            acc_quo_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            match_q   <= 1'b0;
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            acc_rem_q <= acc_rem_d;
            acc_quo_q <= acc_quo_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            match_q   <= match_d;
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        acc_rem_d = acc_rem_q;
        acc_quo_d = acc_quo_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        match_d   = match_q;
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_rem_d = i;
                    acc_quo_d = '0;
                    state_d   = ST_SUB;
                end
            end
            ST_SUB: begin
                // The compare guards the subtraction, so the remainder never
                // underflows. The quotient is bounded by (2^WIDTH-1)/DIVISOR.
                if (acc_rem_q >= DIV_W) begin
                    acc_rem_d = acc_rem_q - DIV_W;
                    acc_quo_d = acc_quo_q + WIDTH'(1);
                end else begin
                    quot_d  = acc_quo_q;
                    rem_d   = acc_rem_q;
                    match_d = (acc_quo_q == MATCH_W);
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
                    if ((acc_quo_q == MATCH_W) && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy and done decode directly from the state register. That makes them
    // fall at once on reset and keeps done to exactly one cycle.
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign is_match = match_q;
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_div10_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div10_seq_ctrl
//
// Directed testbench for div10_seq_ctrl at its default parameters. A
// behavioural model follows each accepted operation. It computes i/10 and
// i%10 and counts down the q+2 busy cycles. A compare process checks the DUT
// against the model on every falling clock edge. Directed tasks add literal
// expectations for latency and for results.
// ---------------------------------------------------------------------------
module tb_div10_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] i;
    logic       busy, done, is_match;
    logic [5:0] quot, rem;
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    div10_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .i        (i),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .is_match (is_match)
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_left  = 0;   // busy cycles remaining for the current operation
    int m_q     = 0;
    int m_r     = 0;
    int e_quot  = 0;
    int e_rem   = 0;
    int e_match = 0;
    int e_done  = 0;
    int e_busy  = 0;
    int e_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; e_quot = 0; e_rem = 0; e_match = 0;
            e_done = 0; e_busy = 0; e_cnt = 0;
        end else begin
            e_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 1) begin
                    e_done  = 1;
                    e_quot  = m_q;
                    e_rem   = m_r;
                    e_match = (m_q == 6) ? 1 : 0;
                    if (e_match == 1 && e_cnt < 255) e_cnt++;
                end
            end else if (start) begin
                m_q    = int'(i) / 10;
                m_r    = int'(i) % 10;
                m_left = m_q + 2;
            end
            e_busy = (m_left > 0) ? 1 : 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en   = 1'b0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",     int'(busy),     e_busy);
            chk("done",     int'(done),     e_done);
            chk("quot",     int'(quot),     e_quot);
            chk("rem",      int'(rem),      e_rem);
            chk("is_match", int'(is_match), e_match);
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
            chk("match_cnt", int'(match_cnt), e_cnt);
`endif
        end
        if (done === 1'b1) done_cnt++;
    end

    // One operation: assert start for the accepting edge, then count edges to
    // done (bounded) and check the literal results and latency.
    task automatic run_op(input int val, input int exp_q, input int exp_r,
                          input int exp_m, input int exp_lat);
        int lat;
        bit seen;
        @(posedge clk); #2;
        start = 1'b1;
        i     = 6'(val);
        @(posedge clk); #2;              // accepting edge
        start = 1'b0;
        i     = 6'($urandom_range(0, 63));
        chk("busy_after_accept", int'(busy), 1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk($sformatf("done_seen_i%0d", val), int'(seen), 1);
        chk($sformatf("latency_i%0d", val), lat, exp_lat);
        chk($sformatf("quot_i%0d", val), int'(quot), exp_q);
        chk($sformatf("rem_i%0d", val), int'(rem), exp_r);
        chk($sformatf("match_i%0d", val), int'(is_match), exp_m);
        @(negedge clk);
        chk($sformatf("busy_low_i%0d", val), int'(busy), 0);
        $display("op i=%0d quot=%0d rem=%0d is_match=%0d latency=%0d", val, quot, rem, is_match, lat);
    endtask

    initial begin
        int dc0;
        int waited;
        rst_n = 1'b0;
        start = 1'b0;
        i     = 6'd0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_rem",  int'(rem),  0);
        chk("rst_match", int'(is_match), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Directed results with hand-computed values
        run_op(63, 6, 3, 1, 7);
        run_op(59, 5, 9, 0, 6);
        run_op(60, 6, 0, 1, 7);
        run_op(0,  0, 0, 0, 1);
        run_op(9,  0, 9, 0, 1);

        // A start while busy is ignored
        dc0 = done_cnt;
        @(posedge clk); #2;
        start = 1'b1; i = 6'd40;
        @(posedge clk); #2;              // accept 40
        start = 1'b0; i = 6'd0;
        @(posedge clk); @(posedge clk); #2;
        start = 1'b1; i = 6'd63;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("ignored_done_count", done_cnt - dc0, 1);
        chk("ignored_quot", int'(quot), 4);
        chk("ignored_rem",  int'(rem),  0);
        $display("op i=40 with busy start quot=%0d rem=%0d dones=%0d", quot, rem, done_cnt - dc0);

        // A start held high gives back-to-back operations (the model checks spacing)
        dc0 = done_cnt;
        @(posedge clk); #2;
        start = 1'b1; i = 6'd20;
        waited = 0;
        while (done_cnt - dc0 < 2 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("held_start_two_dones", int'(done_cnt - dc0 >= 2), 1);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("held start i=20 dones=%0d quot=%0d rem=%0d", done_cnt - dc0, quot, rem);

        // Reset mid-operation takes effect without a clock edge
        @(posedge clk); #2;
        start = 1'b1; i = 6'd63;
        @(posedge clk); #2;              // accept
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quot", int'(quot), 0);
        chk("midrst_rem",  int'(rem),  0);
        chk("midrst_match", int'(is_match), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_done", done_cnt - dc0, 0);
        chk("post_rst_idle", int'(busy), 0);
        $display("mid-op reset: busy=%0d quot=%0d dones_after=%0d", busy, quot, done_cnt - dc0);

        // Full operand sweep
        for (int v = 0; v < 64; v++) begin
            run_op(v, v / 10, v % 10, (v / 10 == 6) ? 1 : 0, v / 10 + 1);
        end
`ifdef DIV10_SEQ_CTRL_MATCH_CNT_EN
        chk("match_cnt_sweep", int'(match_cnt), 4);
        for (int n = 0; n < 260; n++) begin
            run_op(61, 6, 1, 1, 7);
        end
        chk("match_cnt_sat", int'(match_cnt), 255);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
